// File: rtl/drift_tracking_array_pkg.sv
// Shared types for the drift-tracking array.
// common_p carries the clock-domain bundle; clks_alot_p carries the drift
// direction encoding, the accumulator/lockout default width and the
// per-channel FSM state encoding.
// Optional feature macro: DRIFT_TRACKING_APPROX_EN (see drift_tracking_channel).

package common_p;

    // Single clock domain: clock plus its synchronous, active-high reset.
    typedef struct packed {
        logic clk;
        logic sync_rst;
    } clk_dom_s;

endpackage

package clks_alot_p;

    // Default width of the signed drift accumulator and the lockout counter.
    localparam int DRIFT_COUNTER_WIDTH = 8;

    // Value 0 is the positive direction so reset/cleared outputs read as 0.
    typedef enum logic {
        DRIFT_POS = 1'b0,
        DRIFT_NEG = 1'b1
    } drift_direction_e;

    // Per-channel tracking FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_REQ     = 2'd2
    } drift_track_state_e;

    // Maps a sign bit (1 = negative) onto the direction encoding.
    function automatic drift_direction_e dir_of_sign(input logic neg);
        return neg ? DRIFT_NEG : DRIFT_POS;
    endfunction

endpackage

// File: rtl/drift_tracking_array_if.sv
// Single-channel drift request handshake.
// Handshake rule: the master raises req with a stable dir and holds both
// until the slave returns res in the same cycle (req & res = transfer); a
// res seen while req is low carries no meaning and is ignored.

interface drift_tracking_array_if;
    import clks_alot_p::*;

    logic             req;
    logic             res;
    drift_direction_e dir;

    modport master (output req, output dir, input res);
    modport slave  (input req, input dir, output res);

endinterface

// File: rtl/drift_tracking_channel.sv
// One drift-tracking channel: signed saturating accumulator, sticky
// overflow / inverse-drift flags, IDLE/REQ/LOCKOUT FSM driving the
// preemptive drift request, and (with DRIFT_TRACKING_APPROX_EN defined) a
// 2-bit pending counter driving the expected-drift approximation request.
// Without the macro the approximation request is tied low.

module drift_tracking_channel
    import clks_alot_p::*;
#(
    parameter int ACC_WIDTH     = clks_alot_p::DRIFT_COUNTER_WIDTH,
    parameter int LOCKOUT_WIDTH = clks_alot_p::DRIFT_COUNTER_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    input  logic                         drift_i,
    input  drift_direction_e             drift_dir_i,
    input  logic                         valid_edge_i,
    input  logic [ACC_WIDTH-2:0]         max_drift_i,
    input  logic [LOCKOUT_WIDTH-1:0]     lockout_i,
    drift_tracking_array_if.master       pre_if,
    drift_tracking_array_if.master       exp_if,
    output logic                         overflow_o,
    output logic                         inverse_violation_o,
    output drift_track_state_e           state_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    // Two guard bits so acc +/- 2 never wraps before saturation is decided.
    localparam int SUM_W = ACC_WIDTH + 2;
    localparam logic signed [SUM_W-1:0] ONE_S = SUM_W'(1);

    drift_track_state_e          state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LOCKOUT_WIDTH-1:0]    lock_cnt_q, lock_cnt_d;
    drift_direction_e            dir_q, dir_d;
    logic                        ovf_q, ovf_d;
    logic                        inv_q, inv_d;

    logic signed [SUM_W-1:0]     sum_s;
    logic signed [SUM_W-1:0]     max_s;
    logic signed [SUM_W-1:0]     neg_max_s;
    logic                        apply_w;
    logic                        ref_neg_w;

    // Next-state: accumulator update with saturation, sticky flags, FSM.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        lock_cnt_d = lock_cnt_q;
        dir_d      = dir_q;
        ovf_d      = ovf_q;
        inv_d      = inv_q;

        // req is exactly "state is REQ", so req & res reduces to this.
        apply_w   = (state_q == ST_REQ) && pre_if.res;
        max_s     = $signed({3'b000, max_drift_i});
        neg_max_s = -max_s;
        sum_s     = {{2{acc_q[ACC_WIDTH-1]}}, acc_q};

        // With acc at zero the reference sign is the correction just applied,
        // so a drift straight after an application can still be inverse.
        ref_neg_w = (acc_q != '0) ? acc_q[ACC_WIDTH-1] : (dir_q == DRIFT_NEG);

        // Detected drift and the applied correction both land in one sum.
        if (drift_i) begin
            if (drift_dir_i == DRIFT_NEG) begin
                sum_s = sum_s - ONE_S;
            end else begin
                sum_s = sum_s + ONE_S;
            end
        end
        if (apply_w && (acc_q != '0)) begin
            if (acc_q[ACC_WIDTH-1]) begin
                sum_s = sum_s + ONE_S;
            end else begin
                sum_s = sum_s - ONE_S;
            end
        end

        if (clear_i) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            lock_cnt_d = '0;
            dir_d      = DRIFT_POS;
            ovf_d      = 1'b0;
            inv_d      = 1'b0;
        end else if (en_i) begin
            if (sum_s > max_s) begin
                acc_d = max_s[ACC_WIDTH-1:0];
                ovf_d = 1'b1;
            end else if (sum_s < neg_max_s) begin
                acc_d = neg_max_s[ACC_WIDTH-1:0];
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_s[ACC_WIDTH-1:0];
            end

            if (drift_i && (state_q == ST_LOCKOUT) &&
                ((drift_dir_i == DRIFT_NEG) != ref_neg_w)) begin
                inv_d = 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    // Decided on the updated acc so req follows drift by one cycle.
                    if (acc_d != '0) begin
                        state_d = ST_REQ;
                        dir_d   = dir_of_sign(acc_d[ACC_WIDTH-1]);
                    end
                end
                ST_REQ: begin
                    if (pre_if.res) begin
                        state_d    = ST_LOCKOUT;
                        lock_cnt_d = '0;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_cnt_q >= lockout_i) begin
                        state_d = ST_IDLE;
                    end else if (valid_edge_i && (lock_cnt_q != '1)) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            lock_cnt_q <= '0;
            dir_q      <= DRIFT_POS;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            lock_cnt_q <= lock_cnt_d;
            dir_q      <= dir_d;
            ovf_q      <= ovf_d;
            inv_q      <= inv_d;
        end
    end

    assign pre_if.req          = (state_q == ST_REQ);
    assign pre_if.dir          = dir_q;
    assign overflow_o          = ovf_q;
    assign inverse_violation_o = inv_q;
    assign state_o             = state_q;
    assign acc_o               = acc_q;

`ifdef DRIFT_TRACKING_APPROX_EN
    // Opposite drift cancels a pending one, so every pending entry shares a
    // single direction and one register is enough for the oldest direction.
    logic [1:0]       pend_q, pend_d;
    drift_direction_e pend_dir_q, pend_dir_d;
    logic signed [3:0] pend_sum_s;

    // Pending counter next-state: net of drift and acknowledged request.
    always_comb begin
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        pend_sum_s = $signed({2'b00, pend_q});

        if (clear_i) begin
            pend_d     = 2'd0;
            pend_dir_d = DRIFT_POS;
        end else if (en_i) begin
            if (drift_i) begin
                if (pend_q == 2'd0) begin
                    pend_sum_s = 4'sd1;
                    pend_dir_d = drift_dir_i;
                end else if (drift_dir_i == pend_dir_q) begin
                    pend_sum_s = pend_sum_s + 4'sd1;
                end else begin
                    pend_sum_s = pend_sum_s - 4'sd1;
                end
            end
            if ((pend_q != 2'd0) && exp_if.res) begin
                pend_sum_s = pend_sum_s - 4'sd1;
            end
            if (pend_sum_s > 4'sd3) begin
                pend_d = 2'd3;
            end else if (pend_sum_s < 4'sd0) begin
                pend_d = 2'd0;
            end else begin
                pend_d = pend_sum_s[1:0];
            end
        end
    end

    // Pending counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q     <= 2'd0;
            pend_dir_q <= DRIFT_POS;
        end else begin
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
        end
    end

    assign exp_if.req = (pend_q != 2'd0);
    assign exp_if.dir = pend_dir_q;
`else
    logic unused_exp_res;

    assign exp_if.req     = 1'b0;
    assign exp_if.dir     = DRIFT_POS;
    assign unused_exp_res = exp_if.res;
`endif

endmodule

// File: rtl/drift_tracking_array.sv
// Array of CHANNELS independent drift-tracking channels.
// Each channel gets its own handshake interface pair; the top only wires
// the flat ports to them and ORs the sticky flags into any_violation_o.
// Optional feature macro: DRIFT_TRACKING_APPROX_EN (expected-drift request).

module drift_tracking_array
    import clks_alot_p::*;
#(
    parameter int CHANNELS      = 4,
    parameter int ACC_WIDTH     = clks_alot_p::DRIFT_COUNTER_WIDTH,
    parameter int LOCKOUT_WIDTH = clks_alot_p::DRIFT_COUNTER_WIDTH
) (
    input  common_p::clk_dom_s                       sys_dom_i,
    input  logic [CHANNELS-1:0]                      accumulator_en_i,
    input  logic [CHANNELS-1:0]                      clear_state_i,
    input  logic [CHANNELS-1:0]                      drift_detected_i,
    input  drift_direction_e [CHANNELS-1:0]          drift_direction_i,
    input  logic [CHANNELS-1:0]                      any_valid_edge_i,
    input  logic [ACC_WIDTH-2:0]                     max_drift_i,
    input  logic [LOCKOUT_WIDTH-1:0]                 minimum_drift_lockout_duration_i,
    output logic [CHANNELS-1:0]                      preemptive_drift_req_o,
    input  logic [CHANNELS-1:0]                      preemptive_drift_res_i,
    output drift_direction_e [CHANNELS-1:0]          preemptive_drift_direction_o,
    output logic [CHANNELS-1:0]                      expected_drift_req_o,
    input  logic [CHANNELS-1:0]                      expected_drift_res_i,
    output drift_direction_e [CHANNELS-1:0]          expected_drift_direction_o,
    output logic [CHANNELS-1:0]                      drift_acc_overflow_o,
    output logic [CHANNELS-1:0]                      inverse_drift_violation_o,
    output logic                                     any_violation_o,
    output drift_track_state_e [CHANNELS-1:0]        dbg_state_o,
    output logic [CHANNELS-1:0][ACC_WIDTH-1:0]       dbg_acc_o
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        drift_tracking_array_if pre_if ();
        drift_tracking_array_if exp_if ();

        assign pre_if.res                      = preemptive_drift_res_i[g];
        assign exp_if.res                      = expected_drift_res_i[g];
        assign preemptive_drift_req_o[g]       = pre_if.req;
        assign preemptive_drift_direction_o[g] = pre_if.dir;
        assign expected_drift_req_o[g]         = exp_if.req;
        assign expected_drift_direction_o[g]   = exp_if.dir;

        drift_tracking_channel #(
            .ACC_WIDTH     (ACC_WIDTH),
            .LOCKOUT_WIDTH (LOCKOUT_WIDTH)
        ) u_channel (
            .clk_i               (sys_dom_i.clk),
            .rst_i               (sys_dom_i.sync_rst),
            .en_i                (accumulator_en_i[g]),
            .clear_i             (clear_state_i[g]),
            .drift_i             (drift_detected_i[g]),
            .drift_dir_i         (drift_direction_i[g]),
            .valid_edge_i        (any_valid_edge_i[g]),
            .max_drift_i         (max_drift_i),
            .lockout_i           (minimum_drift_lockout_duration_i),
            .pre_if              (pre_if),
            .exp_if              (exp_if),
            .overflow_o          (drift_acc_overflow_o[g]),
            .inverse_violation_o (inverse_drift_violation_o[g]),
            .state_o             (dbg_state_o[g]),
            .acc_o               (dbg_acc_o[g])
        );
    end

    assign any_violation_o = |{drift_acc_overflow_o, inverse_drift_violation_o};

endmodule

// File: tb/tb_drift_tracking_array.sv
// Directed bench for drift_tracking_array (CHANNELS=4, 8-bit widths).
// Table rows drive channel 0 one cycle at a time and compare against
// hand-computed outputs; hand-written sequences cover clear-mid-REQ, the
// multi-channel case and the DRIFT_TRACKING_APPROX_EN pending counter.

module tb_drift_tracking_array;
    import clks_alot_p::*;

    logic clk;
    logic rst;
    common_p::clk_dom_s sys_dom;

    logic [3:0]              en, clr, drift, vedge, pre_res, exp_res;
    drift_direction_e [3:0]  dir;
    logic [6:0]              max_drift;
    logic [7:0]              lockout;
    logic [3:0]              pre_req, exp_req, ovf, inv;
    drift_direction_e [3:0]  pre_dir, exp_dir;
    logic                    any_v;
    drift_track_state_e [3:0] dbg_state;
    logic [3:0][7:0]         dbg_acc;

    int checks = 0;
    int errors = 0;

    assign sys_dom.clk      = clk;
    assign sys_dom.sync_rst = rst;

    drift_tracking_array_if mon_if ();
    assign mon_if.req = pre_req[0];
    assign mon_if.dir = pre_dir[0];
    assign mon_if.res = pre_res[0];

    drift_tracking_array dut (
        .sys_dom_i                        (sys_dom),
        .accumulator_en_i                 (en),
        .clear_state_i                    (clr),
        .drift_detected_i                 (drift),
        .drift_direction_i                (dir),
        .any_valid_edge_i                 (vedge),
        .max_drift_i                      (max_drift),
        .minimum_drift_lockout_duration_i (lockout),
        .preemptive_drift_req_o           (pre_req),
        .preemptive_drift_res_i           (pre_res),
        .preemptive_drift_direction_o     (pre_dir),
        .expected_drift_req_o             (exp_req),
        .expected_drift_res_i             (exp_res),
        .expected_drift_direction_o       (exp_dir),
        .drift_acc_overflow_o             (ovf),
        .inverse_drift_violation_o        (inv),
        .any_violation_o                  (any_v),
        .dbg_state_o                      (dbg_state),
        .dbg_acc_o                        (dbg_acc)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic en, clr, d, n, e, r;
        logic [6:0] mx;
        logic [7:0] lk;
        logic req, dneg, ovf, inv;
        drift_track_state_e st;
        logic [7:0] acc;
    } vec_t;

    vec_t vecs[$];

    localparam drift_track_state_e SI = ST_IDLE;
    localparam drift_track_state_e SL = ST_LOCKOUT;
    localparam drift_track_state_e SR = ST_REQ;

    function automatic vec_t v(input logic en_b, input logic clr_b, input logic d_b,
                               input logic n_b, input logic e_b, input logic r_b,
                               input int mx, input int lk,
                               input logic q, input logic qn, input logic o, input logic iv,
                               input drift_track_state_e s, input int a);
        vec_t t;
        t.en = en_b; t.clr = clr_b; t.d = d_b; t.n = n_b; t.e = e_b; t.r = r_b;
        t.mx = 7'(mx); t.lk = 8'(lk);
        t.req = q; t.dneg = qn; t.ovf = o; t.inv = iv; t.st = s; t.acc = 8'(a);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 4'b1111; clr = '0; drift = '0; vedge = '0; pre_res = '0; exp_res = '0;
        for (int k = 0; k < 4; k++) dir[k] = DRIFT_POS;
    endtask

    initial begin
        // Channel-0 vectors: inputs (en clr d neg edge res max lock), expected
        // outputs after the edge (req dir_neg ovf inv state acc).
        // Saturation at +4 with overflow on the 5th drift.
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,0,0, SR, 1));
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,0,0, SR, 2));
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,0,0, SR, 3));
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,0,0, SR, 4));
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,1,0, SR, 4));
        vecs.push_back(v(1,0,1,0,0,0, 4,0, 1,0,1,0, SR, 4));
        vecs.push_back(v(1,1,0,0,0,0, 4,0, 0,0,0,0, SI, 0));
        // Lockout of 3 edges, stray res ignored, inverse drift, enable hold.
        vecs.push_back(v(1,0,1,0,0,0, 4,3, 1,0,0,0, SR, 1));
        vecs.push_back(v(1,0,0,0,0,1, 4,3, 0,0,0,0, SL, 0));
        vecs.push_back(v(1,0,0,0,1,0, 4,3, 0,0,0,0, SL, 0));
        vecs.push_back(v(1,0,0,0,0,1, 4,3, 0,0,0,0, SL, 0));
        vecs.push_back(v(1,0,1,0,1,0, 4,3, 0,0,0,0, SL, 1));
        vecs.push_back(v(1,0,0,0,1,0, 4,3, 0,0,0,0, SL, 1));
        vecs.push_back(v(1,0,0,0,0,0, 4,3, 0,0,0,0, SI, 1));
        vecs.push_back(v(1,0,0,0,0,0, 4,3, 1,0,0,0, SR, 1));
        vecs.push_back(v(1,0,0,0,0,1, 4,3, 0,0,0,0, SL, 0));
        vecs.push_back(v(1,0,1,1,0,0, 4,3, 0,0,0,1, SL, -1));
        vecs.push_back(v(0,0,1,0,1,0, 4,3, 0,0,0,1, SL, -1));
        vecs.push_back(v(1,1,0,0,0,0, 4,3, 0,0,0,0, SI, 0));
        // Negative requests, net sum on res+drift, one-cycle lockout at 0.
        vecs.push_back(v(1,0,1,1,0,0, 4,0, 1,1,0,0, SR, -1));
        vecs.push_back(v(1,0,1,1,0,0, 4,0, 1,1,0,0, SR, -2));
        vecs.push_back(v(1,0,1,1,0,1, 4,0, 0,1,0,0, SL, -2));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 0,1,0,0, SI, -2));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 1,1,0,0, SR, -2));
        vecs.push_back(v(1,0,0,0,0,1, 4,0, 0,1,0,0, SL, -1));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 0,1,0,0, SI, -1));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 1,1,0,0, SR, -1));
        vecs.push_back(v(1,0,0,0,0,1, 4,0, 0,1,0,0, SL, 0));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 0,1,0,0, SI, 0));
        vecs.push_back(v(1,0,0,0,0,0, 4,0, 0,1,0,0, SI, 0));
        // Negative saturation at -1, then drift+res nets to +1.
        vecs.push_back(v(1,0,1,1,0,0, 1,0, 1,1,0,0, SR, -1));
        vecs.push_back(v(1,0,1,1,0,0, 1,0, 1,1,1,0, SR, -1));
        vecs.push_back(v(1,0,1,0,0,1, 1,0, 0,1,1,0, SL, 1));
        vecs.push_back(v(1,0,0,0,0,0, 1,0, 0,1,1,0, SI, 1));
        vecs.push_back(v(1,0,0,0,0,0, 1,0, 1,0,1,0, SR, 1));
        vecs.push_back(v(1,1,0,0,0,0, 1,0, 0,0,0,0, SI, 0));

        // Reset.
        idle_inputs();
        max_drift = 7'd4;
        lockout   = 8'd0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_pre_req", 32'(pre_req), 32'h0);
        check("rst_pre_dir", 32'(pre_dir), 32'h0);
        check("rst_exp_req", 32'(exp_req), 32'h0);
        check("rst_exp_dir", 32'(exp_dir), 32'h0);
        check("rst_flags", 32'({ovf, inv, any_v}), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        check("rst_acc", 32'(dbg_acc), 32'h0);

        // Table.
        foreach (vecs[i]) begin
            en[0]     = vecs[i].en;
            clr[0]    = vecs[i].clr;
            drift[0]  = vecs[i].d;
            dir[0]    = vecs[i].n ? DRIFT_NEG : DRIFT_POS;
            vedge[0]  = vecs[i].e;
            pre_res[0] = vecs[i].r;
            max_drift = vecs[i].mx;
            lockout   = vecs[i].lk;
            step();
            check($sformatf("row%0d_req", i), 32'(mon_if.req), 32'(vecs[i].req));
            check($sformatf("row%0d_dir", i), 32'(mon_if.dir), 32'(vecs[i].dneg));
            check($sformatf("row%0d_ovf", i), 32'(ovf[0]), 32'(vecs[i].ovf));
            check($sformatf("row%0d_inv", i), 32'(inv[0]), 32'(vecs[i].inv));
            check($sformatf("row%0d_any", i), 32'(any_v), 32'(vecs[i].ovf | vecs[i].inv));
            check($sformatf("row%0d_state", i), 32'(dbg_state[0]), 32'(vecs[i].st));
            check($sformatf("row%0d_acc", i), 32'(dbg_acc[0]), 32'(vecs[i].acc));
        end
        idle_inputs();

        // Clear while REQ has been held 5 cycles; clear beats drift and res.
        max_drift = 7'd2;
        lockout   = 8'd2;
        drift = 4'b0001;
        repeat (3) step();
        drift = 4'b0000;
        check("hold_ovf_set", 32'(ovf[0]), 32'h1);
        check("hold_acc", 32'(dbg_acc[0]), 32'h2);
        repeat (2) step();
        check("hold_req_5cyc", 32'(pre_req[0]), 32'h1);
        clr = 4'b0001; drift = 4'b0001; pre_res = 4'b0001;
        step();
        check("clr_req", 32'(pre_req[0]), 32'h0);
        check("clr_acc", 32'(dbg_acc[0]), 32'h0);
        check("clr_flags", 32'({ovf[0], inv[0], any_v}), 32'h0);
        check("clr_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        idle_inputs();
        step();
        check("clr_after_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        check("clr_after_req", 32'(pre_req[0]), 32'h0);

        // Channels 0 and 3 in the same cycle, opposite directions.
        drift = 4'b1001;
        dir[3] = DRIFT_NEG;
        step();
        drift = 4'b0000;
        check("mc_req", 32'(pre_req), 32'h9);
        check("mc_dir3", 32'(pre_dir[3]), 32'(DRIFT_NEG));
        check("mc_dir0", 32'(pre_dir[0]), 32'(DRIFT_POS));
        check("mc_state12", 32'({dbg_state[2], dbg_state[1]}), 32'({ST_IDLE, ST_IDLE}));
        check("mc_acc12", 32'({dbg_acc[2], dbg_acc[1]}), 32'h0);
        check("mc_acc3", 32'(dbg_acc[3]), 32'hff);
        pre_res = 4'b1000;
        step();
        pre_res = 4'b0000;
        check("mc_req_after_res3", 32'(pre_req), 32'h1);
        check("mc_state3", 32'(dbg_state[3]), 32'(ST_LOCKOUT));
        check("mc_acc3_zero", 32'(dbg_acc[3]), 32'h0);
        clr = 4'b1111;
        step();
        idle_inputs();
        check("mc_clear_all", 32'(dbg_acc), 32'h0);

`ifdef DRIFT_TRACKING_APPROX_EN
        // Pending counter saturates at 3; three acks drain it.
        drift = 4'b0001;
        repeat (4) step();
        drift = 4'b0000;
        check("apx_req_set", 32'(exp_req[0]), 32'h1);
        check("apx_dir_pos", 32'(exp_dir[0]), 32'(DRIFT_POS));
        exp_res = 4'b0001;
        step();
        check("apx_req_after_res1", 32'(exp_req[0]), 32'h1);
        step();
        check("apx_req_after_res2", 32'(exp_req[0]), 32'h1);
        step();
        check("apx_req_after_res3", 32'(exp_req[0]), 32'h0);
        exp_res = 4'b0000;
        // Opposite drift cancels a pending one.
        drift = 4'b0001; dir[0] = DRIFT_NEG;
        step();
        check("apx_neg_req", 32'(exp_req[0]), 32'h1);
        check("apx_neg_dir", 32'(exp_dir[0]), 32'(DRIFT_NEG));
        dir[0] = DRIFT_POS;
        step();
        drift = 4'b0000;
        check("apx_cancel", 32'(exp_req[0]), 32'h0);
`else
        // Approximation path stays tied off.
        drift = 4'b0001; exp_res = 4'b1111;
        step();
        check("apx_off_req1", 32'(exp_req), 32'h0);
        step();
        check("apx_off_req2", 32'(exp_req), 32'h0);
        check("apx_off_dir", 32'(exp_dir), 32'h0);
`endif
        clr = 4'b1111;
        step();
        idle_inputs();
        check("final_clear", 32'({pre_req, ovf, inv, any_v}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drift_tracking_array.md
DRIFT_TRACKING_ARRAY -- requirements
Module: drift_tracking_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning the number of independent drift-tracking channels (1..16).
REQ-002 SHALL have parameter ACC_WIDTH, default clks_alot_p::DRIFT_COUNTER_WIDTH, meaning the signed accumulator width per channel.
REQ-003 SHALL have parameter LOCKOUT_WIDTH, default clks_alot_p::DRIFT_COUNTER_WIDTH, meaning the lockout edge-counter width.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning; clock and reset come first:
- sys_dom_i  in  common_p::clk_dom_s  single clock sys_dom_i.clk; reset sys_dom_i.sync_rst, synchronous, active-high
- accumulator_en_i  in  CHANNELS  per-channel enable
- clear_state_i  in  CHANNELS  per-channel synchronous clear
- drift_detected_i  in  CHANNELS  drift pulse
- drift_direction_i  in  CHANNELS x clks_alot_p::drift_direction_e  direction qualifying drift_detected_i
- any_valid_edge_i  in  CHANNELS  valid-edge strobe
- max_drift_i  in  ACC_WIDTH-1  shared magnitude limit
- minimum_drift_lockout_duration_i  in  LOCKOUT_WIDTH  shared edges required between applications
- preemptive_drift_req_o  out  CHANNELS  request to drift the preemptive clock
- preemptive_drift_res_i  in  CHANNELS  acknowledge
- preemptive_drift_direction_o  out  CHANNELS x drift_direction_e
- expected_drift_req_o / expected_drift_res_i / expected_drift_direction_o  out/in/out  CHANNELS  approximation handshake (macro-gated)
- drift_acc_overflow_o  out  CHANNELS  sticky overflow
- inverse_drift_violation_o  out  CHANNELS  sticky inverse-drift violation
- any_violation_o  out  1  OR of all sticky flags

Function
REQ-005 SHALL update each channel only while its accumulator_en_i=1; when the enable is 0, the channel's state, counters and requests SHALL hold.
REQ-006 SHALL, on drift_detected_i, add +1 (positive direction) or -1 (negative direction) to the signed accumulator.
REQ-007 SHALL, when |acc| would exceed max_drift_i, saturate acc at ±max_drift_i and set drift_acc_overflow_o (sticky).
REQ-008 SHALL, on drift_detected_i whose direction opposes sign(acc) while the channel is in LOCKOUT, set inverse_drift_violation_o (sticky) and still apply the update.
REQ-009 SHALL run a per-channel FSM with states IDLE, LOCKOUT and REQ.
- IDLE to REQ when acc≠0.
- REQ to LOCKOUT on req&res.
- LOCKOUT to IDLE when lock_cnt ≥ minimum_drift_lockout_duration_i.
REQ-010 SHALL increment lock_cnt once per any_valid_edge_i in LOCKOUT, saturating at its maximum, and clear it on LOCKOUT entry.
REQ-011 SHALL assert preemptive_drift_req_o only in REQ and hold it with a stable direction (sign of acc at REQ entry) until res; res without req SHALL be ignored.
REQ-012 SHALL, on the req&res cycle, move acc one step toward zero.
- A simultaneous same-cycle drift_detected_i SHALL also apply, giving a net sum.
REQ-013 SHALL have a latency of 1 cycle: drift_detected_i at cycle N gives req at cycle N+1 when the channel is IDLE.
REQ-014 SHALL, when minimum_drift_lockout_duration_i=0, pass through LOCKOUT in exactly 1 cycle.
REQ-015 SHALL, when clear_state_i=1, zero acc, lock_cnt and both sticky flags, and force IDLE with req deasserted, including when the channel is mid-REQ; clear_state_i SHALL take priority over every other input.

Reset
REQ-016 SHALL, on sync_rst, set all channels to IDLE, acc=0 and lock_cnt=0, and drive all outputs to 0, with direction outputs at the enum value 0.

Configuration
REQ-017 SHALL, with DRIFT_TRACKING_APPROX_EN defined, implement a per-channel 2-bit saturating pending counter.
- drift_detected_i SHALL increment the counter.
- expected_drift_req_o SHALL be asserted while pending≠0, carrying the direction of the oldest pending drift.
- req&res SHALL decrement the counter.
- An opposite-direction drift while pending≠0 SHALL decrement the counter instead of incrementing it.
REQ-018 SHALL, without DRIFT_TRACKING_APPROX_EN, tie expected_drift_req_o and expected_drift_direction_o to 0 and ignore expected_drift_res_i.

Structure
REQ-019 SHALL place drift_direction_e, DRIFT_COUNTER_WIDTH and the FSM state enum drift_track_state_e in package clks_alot_p.
REQ-020 SHALL implement one channel as sub-module drift_tracking_channel, instantiated CHANNELS times via generate; the top level SHALL hold only the OR-reduction.

Verification
REQ-021 SHALL cover, with max_drift=4 and 6 positive drifts: acc saturates at +4, overflow=1 on the 5th drift, and any_violation_o=1.
REQ-022 SHALL cover, with lockout=3, one positive drift and res returned in the same cycle as req: LOCKOUT for exactly 3 valid edges, then IDLE, with req never asserted early.
REQ-023 SHALL cover one negative drift during LOCKOUT after a positive application: inverse_drift_violation_o=1 and acc=-1.
REQ-024 SHALL cover clear_state_i pulsed while REQ has been held for 5 cycles without res: req=0 next cycle, acc=0 and flags=0.
REQ-025 SHALL cover, with CHANNELS=4 and drifts on channels 0 and 3 in the same cycle: independent reqs on bits 0 and 3 only, and channels 1 and 2 unchanged.
REQ-026 SHALL cover, with the macro defined, 3 positive drifts with no res: pending saturates at 3; then 3 res pulses drop expected_drift_req_o after the third.
